// File: rtl/pulse_gen_pkg.sv
// Shared types and sizing helpers for the multi-channel pulse generator.
package pulse_gen_pkg;

  // Config fields are stored at the widest supported counter width.
  localparam int CNT_MAX_W = 32;

  typedef enum logic {
    MODE_CONT    = 1'b0,
    MODE_ONESHOT = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_e;

  typedef struct packed {
    mode_e                mode;
    logic [CNT_MAX_W-1:0] width;
    logic [CNT_MAX_W-1:0] period;
  } ch_cfg_t;

  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int frame_w(input int num_ch, input int cnt_w);
    return ch_idx_w(num_ch) + 1 + 2 * cnt_w;
  endfunction

endpackage

// File: rtl/pulse_gen_channel.sv
// One pulse channel: period counter, shadow and active config, registered output.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | not counting; active config tracks shadow every cycle
//   ST_RUN  | counting 0..period-1; shadow copied to active on wrap only
module pulse_gen_channel
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic    clk_i,
  input  logic    rst_n_i,
  input  logic    en_i,
  input  logic    trig_i,
  input  logic    load_i,
  input  ch_cfg_t cfg_i,
  output logic    pulse_o,
  output logic    busy_o
);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ch_cfg_t          act_q, act_d;
  ch_cfg_t          shd_q, shd_d;
  logic             pulse_q, pulse_d;
  logic             trig_q;
  logic             trig_rise;
  logic             wrap;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      act_q   <= '0;
      shd_q   <= '0;
      pulse_q <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      shd_q   <= shd_d;
      pulse_q <= pulse_d;
      trig_q  <= trig_i;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    act_d     = act_q;
    shd_d     = load_i ? cfg_i : shd_q;
    trig_rise = trig_i & ~trig_q;
    wrap      = (CNT_MAX_W'(cnt_q) == (act_q.period - CNT_MAX_W'(1)));

    if (!en_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      act_d   = shd_q;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          act_d = shd_q;
          cnt_d = '0;
          if ((shd_q.period != '0) && ((shd_q.mode == MODE_CONT) || trig_rise)) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (wrap) begin
            cnt_d = '0;
            act_d = shd_q;
            // Keep running only if both old and new config are continuous and valid.
            if ((act_q.mode == MODE_ONESHOT) || (shd_q.mode == MODE_ONESHOT) ||
                (shd_q.period == '0)) begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    pulse_d = (state_d == ST_RUN) && (CNT_MAX_W'(cnt_d) < act_d.width);
  end

  always_comb begin
    pulse_o = pulse_q;
    busy_o  = (state_q == ST_RUN);
  end

endmodule

// File: rtl/pulse_gen_multi.sv
// Multi-channel pulse generator: serial config frame shifter, channel decode,
// sticky out-of-range error flag and NUM_CH independent channels.
module pulse_gen_multi
  import pulse_gen_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              cfg_sdi,
  input  logic              cfg_shift,
  input  logic              cfg_load,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] trig_i,
  output logic [NUM_CH-1:0] pulse_o,
  output logic [NUM_CH-1:0] busy_o,
  output logic              cfg_err_o
);

  localparam int CH_IDX_W = ch_idx_w(NUM_CH);
  localparam int FRAME_W  = frame_w(NUM_CH, CNT_W);
  localparam logic [CH_IDX_W:0] NUM_CH_L = (CH_IDX_W + 1)'(NUM_CH);

  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic                err_q, err_d;
  logic [CH_IDX_W-1:0] idx;
  logic                idx_ok;
  ch_cfg_t             cfg_new;
  logic [NUM_CH-1:0]   load_vec;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      frame_q <= '0;
      err_q   <= 1'b0;
    end else begin
      frame_q <= frame_d;
      err_q   <= err_d;
    end
  end

  // Load decodes the pre-shift frame, so a same-cycle shift never corrupts it.
  always_comb begin
    idx            = frame_q[FRAME_W-1 -: CH_IDX_W];
    idx_ok         = ({1'b0, idx} < NUM_CH_L);
    cfg_new.mode   = mode_e'(frame_q[2*CNT_W]);
    cfg_new.width  = CNT_MAX_W'(frame_q[2*CNT_W-1 -: CNT_W]);
    cfg_new.period = CNT_MAX_W'(frame_q[CNT_W-1:0]);
    frame_d        = cfg_shift ? {frame_q[FRAME_W-2:0], cfg_sdi} : frame_q;
    err_d          = err_q;
    if (cfg_load) begin
      err_d = ~idx_ok;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      load_vec[i] = cfg_load && idx_ok && (idx == CH_IDX_W'(i));
    end
  end

  assign cfg_err_o = err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pulse_gen_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk_i  (wb_clk_i),
      .rst_n_i(wb_rst_n),
      .en_i   (ch_en[g]),
      .trig_i (trig_i[g]),
      .load_i (load_vec[g]),
      .cfg_i  (cfg_new),
      .pulse_o(pulse_o[g]),
      .busy_o (busy_o[g])
    );
  end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Self-checking bench for pulse_gen_multi: directed tables, corner sequences
// and randomized traffic against an elapsed-cycle reference model.
module tb_pulse_gen_multi;
  import pulse_gen_pkg::*;

  localparam int NCH = 5;
  localparam int CW  = 8;
  localparam int IW  = 3;
  localparam int FW  = IW + 1 + 2 * CW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sdi = 1'b0, shift = 1'b0, load = 1'b0;
  logic [NCH-1:0] en = '0, trig = '0;
  logic [NCH-1:0] pulse, busy;
  logic err;

  always #5 clk = ~clk;

  pulse_gen_multi #(.NUM_CH(NCH), .CNT_W(CW)) dut (
    .wb_clk_i (clk),
    .wb_rst_n (rst_n),
    .cfg_sdi  (sdi),
    .cfg_shift(shift),
    .cfg_load (load),
    .ch_en    (en),
    .trig_i   (trig),
    .pulse_o  (pulse),
    .busy_o   (busy),
    .cfg_err_o(err)
  );

  // Reference model state: configs as integers, runs tracked by start cycle.
  logic [FW-1:0] m_frame;
  logic          m_err;
  int  sh_p[NCH], sh_w[NCH], ac_p[NCH], ac_w[NCH], start[NCH];
  bit  sh_m[NCH], ac_m[NCH], run[NCH], tprev[NCH];
  logic [NCH-1:0] e_pulse, e_busy;
  int  cyc;
  int  n_cmp = 0, n_err = 0;
  bit  rnd_io = 1'b0;

  typedef struct packed {
    logic [NCH-1:0] en;
    logic [NCH-1:0] tr;
    logic [NCH-1:0] ep;
    logic [NCH-1:0] eb;
  } vec_t;
  vec_t vec[19];
  bit   t3[16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_frame = '0;
    m_err   = 1'b0;
    cyc     = 0;
    e_pulse = '0;
    e_busy  = '0;
    for (int c = 0; c < NCH; c++) begin
      sh_p[c] = 0; sh_w[c] = 0; sh_m[c] = 0;
      ac_p[c] = 0; ac_w[c] = 0; ac_m[c] = 0;
      run[c] = 0; start[c] = 0; tprev[c] = 0;
    end
  endtask

  task automatic model_edge();
    int li;
    bit lok, rise, cont_ok;
    li  = int'(m_frame[FW-1 -: IW]);
    lok = load && (li < NCH);
    if (load) m_err = lok ? 1'b0 : 1'b1;
    for (int c = 0; c < NCH; c++) begin
      rise = trig[c] && !tprev[c];
      if (!en[c]) begin
        run[c] = 0;
        ac_p[c] = sh_p[c]; ac_w[c] = sh_w[c]; ac_m[c] = sh_m[c];
      end else if (!run[c]) begin
        ac_p[c] = sh_p[c]; ac_w[c] = sh_w[c]; ac_m[c] = sh_m[c];
        if (sh_p[c] != 0 && (!sh_m[c] || rise)) begin
          run[c] = 1;
          start[c] = cyc;
        end
      end else if (cyc - start[c] == ac_p[c]) begin
        cont_ok = !ac_m[c] && !sh_m[c] && (sh_p[c] != 0);
        ac_p[c] = sh_p[c]; ac_w[c] = sh_w[c]; ac_m[c] = sh_m[c];
        if (cont_ok) start[c] = cyc;
        else run[c] = 0;
      end
      e_busy[c]  = run[c];
      e_pulse[c] = run[c] && ((cyc - start[c]) < ac_w[c]);
      tprev[c]   = trig[c];
      if (lok && li == c) begin
        sh_m[c] = m_frame[2*CW];
        sh_w[c] = int'(m_frame[2*CW-1 -: CW]);
        sh_p[c] = int'(m_frame[CW-1:0]);
      end
    end
    if (shift) m_frame = {m_frame[FW-2:0], sdi};
    cyc++;
  endtask

  task automatic tick(input string nm);
    if (rnd_io) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(15) == 0) en[c] = ~en[c];
        trig[c] = ($urandom_range(3) == 0);
      end
    end
    model_edge();
    @(posedge clk);
    #1;
    check({nm, ".pulse"}, 32'(pulse), 32'(e_pulse));
    check({nm, ".busy"}, 32'(busy), 32'(e_busy));
    check({nm, ".err"}, 32'(err), 32'(m_err));
  endtask

  task automatic shift_frame(input int idx, input bit md, input int w, input int p, input string nm);
    logic [FW-1:0] f;
    f = {IW'(idx), md, CW'(w), CW'(p)};
    for (int i = FW - 1; i >= 0; i--) begin
      shift = 1'b1;
      sdi   = f[i];
      tick(nm);
    end
    shift = 1'b0;
    sdi   = 1'b0;
  endtask

  task automatic send_frame(input int idx, input bit md, input int w, input int p, input string nm);
    shift_frame(idx, md, w, p, nm);
    load = 1'b1;
    tick(nm);
    load = 1'b0;
  endtask

  initial begin
    vec[0]  = '{5'b00001, 5'b00000, 5'b00001, 5'b00001};
    vec[1]  = '{5'b00001, 5'b00000, 5'b00001, 5'b00001};
    vec[2]  = '{5'b00001, 5'b00000, 5'b00000, 5'b00001};
    vec[3]  = '{5'b00001, 5'b00000, 5'b00000, 5'b00001};
    vec[4]  = '{5'b00001, 5'b00000, 5'b00000, 5'b00001};
    vec[5]  = '{5'b00001, 5'b00000, 5'b00001, 5'b00001};
    vec[6]  = '{5'b00001, 5'b00000, 5'b00001, 5'b00001};
    vec[7]  = '{5'b00001, 5'b00000, 5'b00000, 5'b00001};
    vec[8]  = '{5'b00001, 5'b00000, 5'b00000, 5'b00001};
    vec[9]  = '{5'b00001, 5'b00000, 5'b00000, 5'b00001};
    vec[10] = '{5'b00010, 5'b00000, 5'b00000, 5'b00000};
    vec[11] = '{5'b00010, 5'b00010, 5'b00010, 5'b00010};
    vec[12] = '{5'b00010, 5'b00000, 5'b00010, 5'b00010};
    vec[13] = '{5'b00010, 5'b00010, 5'b00010, 5'b00010};
    vec[14] = '{5'b00010, 5'b00000, 5'b00000, 5'b00010};
    vec[15] = '{5'b00010, 5'b00000, 5'b00000, 5'b00010};
    vec[16] = '{5'b00010, 5'b00000, 5'b00000, 5'b00010};
    vec[17] = '{5'b00010, 5'b00000, 5'b00000, 5'b00000};
    vec[18] = '{5'b00010, 5'b00000, 5'b00000, 5'b00000};
    t3 = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0};

    // Reset held while every input toggles.
    model_reset();
    #2;
    for (int i = 0; i < 8; i++) begin
      {sdi, shift, load} = 3'($urandom);
      en   = NCH'($urandom);
      trig = NCH'($urandom);
      @(posedge clk);
      #1;
      check("rst.pulse", 32'(pulse), 32'(0));
      check("rst.busy", 32'(busy), 32'(0));
      check("rst.err", 32'(err), 32'(0));
    end
    rst_n = 1'b1;
    tick("rst_rel");
    {sdi, shift, load} = 3'b000;
    en = '0;
    trig = '0;
    tick("idle");

    // Continuous CH0 5/2 and one-shot CH1 6/3 via vector table.
    send_frame(0, 1'b0, 2, 5, "ld0");
    send_frame(1, 1'b1, 3, 6, "ld1");
    for (int i = 0; i < 19; i++) begin
      en   = vec[i].en;
      trig = vec[i].tr;
      tick("vec");
      check($sformatf("vec%0d.pulse", i), 32'(pulse), 32'(vec[i].ep));
      check($sformatf("vec%0d.busy", i), 32'(busy), 32'(vec[i].eb));
    end
    en = '0;
    trig = '0;
    tick("idle");

    // CH2 8/4 reloaded to 4/1 mid-period; change lands on the next wrap.
    send_frame(2, 1'b0, 4, 8, "ld2");
    shift_frame(2, 1'b0, 1, 4, "sh2");
    en[2] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      load = (i == 3);
      tick("t3");
      check($sformatf("t3_%0d", i), 32'(pulse[2]), 32'(t3[i]));
    end
    load = 1'b0;
    en = '0;
    tick("idle");

    // Out-of-range channel index sets the sticky error; a valid load clears it.
    send_frame(5, 1'b0, 1, 2, "bad");
    check("err_set", 32'(err), 32'(1));
    en[0] = 1'b1;
    for (int i = 0; i < 6; i++) tick("bad_run");
    en = '0;
    send_frame(0, 1'b0, 2, 5, "good");
    check("err_clr", 32'(err), 32'(0));

    // Period 0, width 0, width == period, enable drop, async reset.
    send_frame(3, 1'b0, 3, 0, "p0");
    en[3] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick("p0");
      check("p0.pulse", 32'(pulse[3]), 32'(0));
      check("p0.busy", 32'(busy[3]), 32'(0));
    end
    send_frame(4, 1'b0, 0, 3, "w0");
    en[4] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick("w0");
      check("w0.pulse", 32'(pulse[4]), 32'(0));
      check("w0.busy", 32'(busy[4]), 32'(1));
    end
    send_frame(3, 1'b0, 3, 3, "wp");
    for (int i = 0; i < 5; i++) begin
      tick("wp");
      check("wp.pulse", 32'(pulse[3]), 32'(1));
    end
    en[3] = 1'b0;
    tick("endrop");
    check("endrop.pulse", 32'(pulse[3]), 32'(0));
    en[3] = 1'b1;
    tick("wp2");
    tick("wp2");
    check("pre_rst.pulse", 32'(pulse[3]), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.pulse", 32'(pulse), 32'(0));
    check("async_rst.busy", 32'(busy), 32'(0));
    en = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    tick("post_rst");

    // Randomized traffic against the model.
    rnd_io = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(99) < 3) begin
        send_frame(int'($urandom_range(7)), 1'($urandom), int'($urandom_range(10)),
                   int'($urandom_range(9)), "rnd_ld");
      end else begin
        shift = 1'($urandom);
        sdi   = 1'($urandom);
        load  = ($urandom_range(19) == 0);
        tick("rnd");
      end
      shift = 1'b0;
      load  = 1'b0;
    end
    rnd_io = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
